// File: rtl/sed_supervisor_pkg.sv
// Shared definitions for the SED supervisor: state encoding and small helpers.
package sed_supervisor_pkg;

  localparam logic [2:0] SUP_IDLE    = 3'd0;
  localparam logic [2:0] SUP_STARTUP = 3'd1;
  localparam logic [2:0] SUP_RUN     = 3'd2;
  localparam logic [2:0] SUP_REARM   = 3'd3;
  localparam logic [2:0] SUP_FAULT   = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = SUP_IDLE,
    StStartup = SUP_STARTUP,
    StRun     = SUP_RUN,
    StRearm   = SUP_REARM,
    StFault   = SUP_FAULT
  } sup_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/err_filter.sv
// Synchronizes an asynchronous status flag, qualifies it over FILTER_CYCLES
// consecutive high cycles and produces a rising-edge pulse of the qualified level.
module err_filter #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          level_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != FW'(FILTER_CYCLES)) begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  // Gating with sync2_q drops the level on the very first low synchronized cycle.
  assign level_o = sync2_q && (cnt_q == FW'(FILTER_CYCLES));
  assign rise_o  = level_o && !level_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_o;
    end
  end

endmodule

// File: rtl/sed_supervisor.sv
// Supervises the SED machine: startup delay, error qualification and counting,
// re-arm pulses on the detector enable, and a latched fault at the count threshold.
module sed_supervisor
  import sed_supervisor_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned REARM_CYCLES   = 256,
  parameter int unsigned THRESHOLD      = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             sed_err_i,
  output logic             sed_enable_o,
  output logic             fault_o,
  output logic             event_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [2:0]       state_o
);

  localparam int unsigned TW = $clog2(max_u(STARTUP_CYCLES, REARM_CYCLES)) + 1;

  sup_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             event_q, event_d;
  logic             enable_q, fault_q;
  logic             err_f, err_f_rise;

  err_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_err_filter (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .async_i(sed_err_i),
    .level_o(err_f),
    .rise_o (err_f_rise)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    event_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StStartup;
          timer_d = '0;
        end
      end
      StStartup: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (timer_q == TW'(STARTUP_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StRun: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (err_f_rise && !clr_i) begin
          event_d = 1'b1;
          cnt_d   = cnt_inc;
          if (32'(cnt_inc) >= THRESHOLD) begin
            state_d = StFault;
          end else begin
            state_d = StRearm;
            timer_d = '0;
          end
        end
      end
      StRearm: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (timer_q == TW'(REARM_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StFault: begin
        if (clr_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A clear always empties the counter; in RUN it also suppresses a coincident event.
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      cnt_q    <= '0;
      event_q  <= 1'b0;
      enable_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      event_q  <= event_d;
      enable_q <= (state_d == StRun);
      fault_q  <= (state_d == StFault);
    end
  end

  assign sed_enable_o = enable_q;
  assign fault_o      = fault_q;
  assign event_o      = event_q;
  assign err_cnt_o    = cnt_q;
  assign state_o      = state_q;

endmodule

// File: doc/sed_supervisor.md
Name: sed_supervisor

Overview:
Consumes the single-event-upset detector's error flag and drives that detector's enable. Sequences a post-reset startup delay, filters and counts error events, and re-arms the detector after each event by pulsing its enable low. Latches a protection fault once the error count reaches a threshold. Sits between the SED machine and the converter protection/status logic.

Parameters:
STARTUP_CYCLES, 1000, clk_i cycles sed_enable_o stays low after entering STARTUP (>=1)
FILTER_CYCLES, 4, consecutive synchronized-high cycles needed to qualify an error (>=1)
REARM_CYCLES, 256, clk_i cycles sed_enable_o is held low after a non-fatal event (>=1)
THRESHOLD, 3, error count that latches the fault (1..2^CNT_W-1)
CNT_W, 8, width of the error counter

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
en_i  in  1  supervisor enable (level, synchronous to clk_i)
clr_i  in  1  one-cycle clear: clears the fault and the error counter
sed_err_i  in  1  SED error flag (asynchronous to clk_i)
sed_enable_o  out  1  enable to the SED machine
fault_o  out  1  latched SED fault to protection logic
event_o  out  1  one-cycle pulse per qualified error event
err_cnt_o  out  CNT_W  saturating count of qualified events
state_o  out  3  current FSM state code

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE; all outputs 0; sync, filter, and all counters 0.
- Sync and filter:
  - sed_err_i passes through a 2-FF synchronizer to produce err_s.
  - The filter counter increments while err_s=1 and clears to 0 on any err_s=0 cycle.
  - err_f asserts when the filter counter reaches FILTER_CYCLES. It deasserts on the first err_s=0 cycle.
  - err_f_rise = err_f & ~err_f_d.
- Latency:
  - sed_err_i held high, first sampled at edge N: err_f is high after edge N+1+FILTER_CYCLES.
  - event_o and the err_cnt_o update occur after edge N+2+FILTER_CYCLES.
- State codes: IDLE=0, STARTUP=1, RUN=2, REARM=3, FAULT=4.
- FSM transitions:
  - IDLE: sed_enable_o=0. Goes to STARTUP when en_i=1; the timer loads 0.
  - STARTUP: sed_enable_o=0. Timer counts to STARTUP_CYCLES-1, then goes to RUN.
  - RUN: sed_enable_o=1.
    - On err_f_rise: event_o=1 and err_cnt_o increments, saturating at 2^CNT_W-1.
    - If the new count >= THRESHOLD: go to FAULT.
    - Otherwise: go to REARM; the timer loads 0.
  - REARM: sed_enable_o=0. Timer counts to REARM_CYCLES-1, then goes to RUN.
  - FAULT: fault_o=1, sed_enable_o=0.
    - Exits only on clr_i: clears fault_o and err_cnt_o, then goes to IDLE.
    - en_i is ignored.
- en_i=0 in STARTUP, RUN, or REARM: go to IDLE next cycle and drop sed_enable_o.
  - err_cnt_o is retained.
  - A simultaneous err_f_rise is dropped.
- Event detection:
  - Only in RUN; err_f_rise in any other state is ignored.
  - An error held high across REARM does not recount, because no new rising edge occurs.
- clr_i in a non-FAULT state: clears err_cnt_o only, with no state change.
  - clr_i and err_f_rise in the same cycle: clear wins, the event is dropped, and event_o=0.
- Registered outputs: sed_enable_o, fault_o, and state_o are registered, with no combinational path from inputs.
  - sed_enable_o goes high on the first cycle RUN is entered.
- Timer width: $clog2(max(STARTUP_CYCLES, REARM_CYCLES))+1.

Decomposition:
- Shared package: state encoding constants (SUP_IDLE..SUP_FAULT, 3 bits).
- Sub-module err_filter: 2-FF synchronizer, FILTER_CYCLES qualifier, and rising-edge pulse output. Reused for other asynchronous status flags.
- FSM, timer, and counter stay in sed_supervisor.

Test Plan:
All tests use STARTUP_CYCLES=10, FILTER_CYCLES=4, REARM_CYCLES=8, THRESHOLD=3.
1. Release reset with en_i=1 → state_o=1 for 10 cycles; sed_enable_o rises on the 11th cycle; fault_o=0, err_cnt_o=0.
2. In RUN, sed_err_i high for 3 cycles, then a 6-cycle pulse → first pulse ignored. Second pulse gives event_o exactly once at N+6, err_cnt_o=1, then sed_enable_o low for 8 cycles and back to RUN.
3. Three qualified events, each separated by return to RUN → err_cnt_o=3, fault_o=1, state_o=4. sed_enable_o stays 0; toggling en_i has no effect.
4. clr_i pulse in FAULT → fault_o=0 and err_cnt_o=0 next cycle; state IDLE, then STARTUP because en_i=1.
5. clr_i coincident with the err_f_rise cycle, count=1 → err_cnt_o=0, event_o=0, remains in RUN.
6. Assert rst_n_i low mid-REARM, asynchronously between edges → all outputs 0 immediately, without waiting for a clock edge; count lost; restart from STARTUP after release.
